// File: rtl/uart_rx_fifo_if.sv
// Receive-side bus between the UART receiver FIFO and its consumer (CPU IOT).
//   rx_read    : consumer -> receiver, one-clk pop of the head entry
//   rx_rdy     : receiver -> consumer, FIFO not empty
//   rx_data    : head entry data, LSB = first received bit
//   rx_perr    : head entry parity error
//   rx_ferr    : head entry framing error
//   rx_brk     : head entry is a break
//   rx_overrun : sticky, a frame was dropped because the FIFO was full
//   rx_count   : number of entries held
interface uart_rx_fifo_if #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 4
);
  logic                         rx_read;
  logic                         rx_rdy;
  logic [DATA_BITS-1:0]         rx_data;
  logic                         rx_perr;
  logic                         rx_ferr;
  logic                         rx_brk;
  logic                         rx_overrun;
  logic [$clog2(DEPTH+1)-1:0]   rx_count;

  modport master (
    input  rx_read,
    output rx_rdy, rx_data, rx_perr, rx_ferr, rx_brk, rx_overrun, rx_count
  );

  modport slave (
    output rx_read,
    input  rx_rdy, rx_data, rx_perr, rx_ferr, rx_brk, rx_overrun, rx_count
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with 2-flop input synchroniser, 3-sample
// majority voting, false-start rejection, break detection and a
// first-word-fall-through receive FIFO with sticky overrun.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   os_tick : one-clk enable at OVERSAMPLE x baud; rx is only sampled here
//   rx      : asynchronous serial input, idle high
//   bus     : FIFO read side (uart_rx_fifo_if.master)
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int DEPTH      = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           os_tick,
  input  logic           rx,
  uart_rx_fifo_if.master bus
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int EW = DATA_BITS + 3;

  localparam logic [CW-1:0] CNT_S0   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] CNT_DEC  = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t               state_q, state_d;
  logic [1:0]           sync_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] shr_q, shr_d;
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 push;
  logic                 rs, maj, tick_dec, tick_end, ferr_now, brk_now;
  logic [EW-1:0]        entry;

  logic [EW-1:0]        mem_q [DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [NW-1:0]        count_q;
  logic                 ovr_q;
  logic                 full, empty, pop, wr_en;
  logic [EW-1:0]        head;

  // Synchronised line and per-bit decision
  assign rs       = sync_q[1];
  assign maj      = maj3(smp_q[0], smp_q[1], rs);
  assign tick_dec = os_tick && (cnt_q == CNT_DEC);
  assign tick_end = os_tick && (cnt_q == CNT_LAST);
  assign ferr_now = ferr_q | ~maj;
  // Break: framing error with every data and parity bit low
  assign brk_now  = ferr_now && (shr_q == '0) && ((PARITY == 0) || !par_q);
  assign entry    = {brk_now, ferr_now, perr_q, shr_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    smp_d   = smp_q;
    shr_d   = shr_q;
    par_d   = par_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    push    = 1'b0;

    if (os_tick && state_q != S_IDLE) begin
      cnt_d = tick_end ? '0 : cnt_q + CW'(1);
      if (cnt_q == CNT_S0) smp_d[0] = rs;
      if (cnt_q == CNT_S1) smp_d[1] = rs;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (os_tick && !rs) begin
          state_d = S_START;
          bit_d   = '0;
          stop_d  = 1'b0;
          par_d   = 1'b0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: begin
        if (tick_dec && maj) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (tick_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tick_dec) shr_d = {maj, shr_q[DATA_BITS-1:1]};
        if (tick_end) begin
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (tick_dec) begin
          par_d  = maj;
          perr_d = (PARITY == 1) ? ~(^shr_q ^ maj) : (^shr_q ^ maj);
        end
        if (tick_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (tick_dec) begin
          ferr_d = ferr_now;
          // Leave on the last stop decision so a short stop bit still resyncs
          if (stop_q == STOP_LAST) begin
            push    = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else if (tick_end) begin
          stop_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], rx};
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
    end
  end

  always_ff @(posedge clk) begin
    smp_q  <= smp_d;
    shr_q  <= shr_d;
    par_q  <= par_d;
    perr_q <= perr_d;
    ferr_q <= ferr_d;
  end

  // Receive FIFO (first word fall through)
  assign full  = (count_q == NW'(DEPTH));
  assign empty = (count_q == '0);
  assign pop   = bus.rx_read && !empty;
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + AW'(1);
      if (pop)   rd_q <= rd_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + NW'(1);
        2'b01:   count_q <= count_q - NW'(1);
        default: count_q <= count_q;
      endcase
      // A drop in the same cycle as a read keeps the flag set
      if (push && full && !pop) ovr_q <= 1'b1;
      else if (bus.rx_read)     ovr_q <= 1'b0;
    end
  end

  assign head           = mem_q[rd_q];
  assign bus.rx_rdy     = !empty;
  assign bus.rx_data    = empty ? '0 : head[DATA_BITS-1:0];
  assign bus.rx_perr    = !empty && head[DATA_BITS];
  assign bus.rx_ferr    = !empty && head[DATA_BITS+1];
  assign bus.rx_brk     = !empty && head[DATA_BITS+2];
  assign bus.rx_overrun = ovr_q;
  assign bus.rx_count   = count_q;

endmodule
